// File: rtl/phase_link_master.sv
// Phase-table link master: sends command byte sequences over a UART byte interface
// and checks each byte's echo, with timeout, abort (0xFF) and receive-flush handling.
module phase_link_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned FLUSH_CYCLES   = 100000,
   parameter int unsigned MAX_ENTRIES    = 51
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tbl_we,
   input  logic [5:0] tbl_addr,
   input  logic [7:0] tbl_data,
   input  logic [5:0] tbl_len,
   input  logic       cmd_start,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_arg,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] status_byte
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_ECHO, S_ABORT, S_FLUSH, S_DONE} state_e;
   typedef enum logic [1:0] {STEP_HEAD, STEP_BODY, STEP_TAIL} step_e;
   typedef enum logic [2:0] {OP_ARM, OP_DISARM, OP_LOAD, OP_TRIGGER, OP_SET_CAP, OP_STATUS} op_e;

   // Only the low 5 bits of an entry are ever transmitted, so only those are stored.
   logic [4:0] table_mem [MAX_ENTRIES];
   logic       unused_bits;
   assign unused_bits = ^{tbl_data[7:5], cmd_arg[7:4]};

   always_ff @(posedge clk) begin
      if (tbl_we && (32'(tbl_addr) < MAX_ENTRIES)) table_mem[tbl_addr] <= tbl_data[4:0];
   end

   state_e        state_q, state_d;
   step_e         step_q, step_d;
   op_e           op_q, op_d;
   logic [3:0]    arg_q, arg_d;
   logic [5:0]    len_q, len_d, idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sent_q, sent_d, tx_data_q, tx_data_d, status_q, status_d;
   logic          tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [7:0]    cur_byte;
   logic          bad_req, last_byte;

   always_comb begin
      cur_byte = '0;
      unique case (step_q)
         STEP_HEAD: begin
            unique case (op_q)
               OP_ARM:     cur_byte = 8'd65;
               OP_DISARM:  cur_byte = 8'd64;
               OP_LOAD:    cur_byte = 8'd66;
               OP_TRIGGER: cur_byte = 8'd70;
               OP_SET_CAP: cur_byte = 8'd69;
               OP_STATUS:  cur_byte = 8'd63;
               default:    cur_byte = '0;
            endcase
         end
         STEP_BODY: cur_byte = (op_q == OP_SET_CAP) ? {4'b0, arg_q} : {3'b0, table_mem[idx_q]};
         STEP_TAIL: cur_byte = 8'd68;
         default:   cur_byte = '0;
      endcase
   end

   assign bad_req = (cmd_op > 3'd5) ||
                    ((cmd_op == 3'd2) && ((tbl_len == '0) || (32'(tbl_len) > MAX_ENTRIES)));
   assign last_byte = (step_q == STEP_TAIL) ||
                      ((step_q == STEP_BODY) && (op_q == OP_SET_CAP)) ||
                      ((step_q == STEP_HEAD) && (op_q != OP_SET_CAP) && (op_q != OP_LOAD));

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      op_d       = op_q;
      arg_d      = arg_q;
      len_d      = len_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      sent_d     = sent_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      err_d      = err_q;
      err_code_d = err_code_q;
      status_d   = status_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               step_d = STEP_HEAD;
               idx_d  = '0;
               cnt_d  = '0;
               if (bad_req) begin
                  state_d    = S_DONE;
                  err_d      = 1'b1;
                  err_code_d = 2'd3;
               end else begin
                  op_d       = op_e'(cmd_op);
                  arg_d      = cmd_arg[3:0];
                  len_d      = tbl_len;
                  state_d    = S_SEND;
                  err_d      = 1'b0;
                  err_code_d = 2'd0;
               end
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = cur_byte;
               sent_d     = cur_byte;
               cnt_d      = '0;
               state_d    = S_WAIT_ECHO;
            end
         end
         S_WAIT_ECHO: begin
            // rx_ready is checked before the timeout so a last-cycle echo still counts.
            if (rx_ready) begin
               if ((sent_q == 8'd63) || (rx_data == sent_q)) begin
                  if (sent_q == 8'd63) status_d = rx_data;
                  if (last_byte) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_SEND;
                     if (step_q == STEP_HEAD) begin
                        step_d = STEP_BODY;
                        idx_d  = '0;
                     end else if (idx_q == len_q - 6'd1) begin
                        step_d = STEP_TAIL;
                     end else begin
                        idx_d = idx_q + 6'd1;
                     end
                  end
               end else begin
                  state_d    = S_ABORT;
                  err_code_d = 2'd2;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d    = S_ABORT;
               err_code_d = 2'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ABORT: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = 8'hFF;
               cnt_d      = '0;
               state_d    = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (cnt_q == FL_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         step_q     <= STEP_HEAD;
         op_q       <= OP_ARM;
         arg_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         sent_q     <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         status_q   <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         sent_q     <= sent_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         status_q   <= status_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign status_byte = status_q;

endmodule

// File: tb/tb_phase_link_master.sv
// Bench for phase_link_master: vector table of commands, echo responder with
// scoreboard of expected transmitted bytes, plus reset and busy corner sequences.
module tb_phase_link_master;

   localparam int unsigned TO   = 100;
   localparam int unsigned FL   = 20;
   localparam int unsigned MAXE = 51;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       tbl_we = 1'b0;
   logic [5:0] tbl_addr = '0, tbl_len = '0;
   logic [7:0] tbl_data = '0, cmd_arg = '0, rx_data = '0, tx_data, status_byte;
   logic       cmd_start = 1'b0, tx_busy = 1'b0, rx_ready = 1'b0;
   logic [2:0] cmd_op = '0;
   logic       tx_start, busy, done, err;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   phase_link_master #(.TIMEOUT_CYCLES(TO), .FLUSH_CYCLES(FL), .MAX_ENTRIES(MAXE)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .tbl_len(tbl_len), .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data),
      .rx_ready(rx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .status_byte(status_byte)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] arg;
      logic [5:0] len;
      int         delay;
      bit         silent;
      int         corrupt;
      logic [7:0] reply;
      int         abort_after;
      logic       e_err;
      logic [1:0] e_code;
      logic [7:0] e_st;
   } vec_t;

   int         n_vec = 0, n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] shadow[MAXE];
   int         cfg_delay = 2, cfg_corrupt = -1;
   bit         cfg_silent = 1'b0;
   logic [7:0] cfg_reply = '0;
   int         txn_idx = 0, cyc = 0, busy_cnt = 0, pend_cnt = 0;
   int         tx_cyc[$];
   bit         pend = 1'b0;
   logic [7:0] pend_byte = '0, mon_exp = '0;
   vec_t       vecs[18];

   always @(posedge clk) cyc++;

   // Far-end model: checks each transmitted byte against the scoreboard and echoes it.
   always @(negedge clk) begin
      rx_ready = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
         busy_cnt = 0;
         tx_busy = 1'b0;
      end else begin
         if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
               rx_ready = 1'b1;
               rx_data = pend_byte;
               pend = 1'b0;
            end
         end
         if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
         end else tx_busy = 1'b0;
         if (tx_start) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL tx_byte: got unexpected byte %0d, required no transmission", tx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (tx_data !== mon_exp) begin
                  n_err++;
                  $display("FAIL tx_byte[%0d]: got %0d, required %0d", txn_idx, tx_data, mon_exp);
               end
            end
            tx_cyc.push_back(cyc);
            busy_cnt = 3;
            tx_busy = 1'b1;
            if (tx_data == 8'hFF) begin
               pend = 1'b1; pend_cnt = 2; pend_byte = 8'hFF;
            end else if (!cfg_silent) begin
               pend = 1'b1;
               pend_cnt = cfg_delay;
               pend_byte = (txn_idx == cfg_corrupt) ? tx_data + 8'd1 :
                           ((tx_data == 8'd63) ? cfg_reply : tx_data);
            end
            txn_idx++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] arg, input logic [5:0] len,
                               input int delay, input bit silent, input int corrupt,
                               input logic [7:0] reply, input int abort_after,
                               input logic e_err, input logic [1:0] e_code, input logic [7:0] e_st);
      vec_t v;
      v.op = op; v.arg = arg; v.len = len; v.delay = delay; v.silent = silent;
      v.corrupt = corrupt; v.reply = reply; v.abort_after = abort_after;
      v.e_err = e_err; v.e_code = e_code; v.e_st = e_st;
      return v;
   endfunction

   task automatic push_expected(input vec_t v);
      logic [7:0] seq[$];
      bit bad;
      bad = (v.op > 3'd5) || (v.op == 3'd2 && (v.len == 0 || v.len > MAXE));
      if (!bad) begin
         case (v.op)
            3'd0: seq.push_back(8'd65);
            3'd1: seq.push_back(8'd64);
            3'd3: seq.push_back(8'd70);
            3'd5: seq.push_back(8'd63);
            3'd4: begin seq.push_back(8'd69); seq.push_back({4'b0, v.arg[3:0]}); end
            default: begin
               seq.push_back(8'd66);
               for (int i = 0; i < int'(v.len); i++) seq.push_back({3'b0, shadow[i][4:0]});
               seq.push_back(8'd68);
            end
         endcase
         if (v.abort_after >= 0) begin
            while (seq.size() > v.abort_after) void'(seq.pop_back());
            seq.push_back(8'hFF);
         end
      end
      foreach (seq[i]) exp_q.push_back(seq[i]);
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] arg, input logic [5:0] len);
      @(negedge clk);
      cmd_op = op; cmd_arg = arg; tbl_len = len; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic wait_done_and_check(input string tag, input logic e_err, input logic [1:0] e_code,
                                      input logic [7:0] e_st, input bit check_gap);
      int c;
      c = 0;
      while (done !== 1'b1 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (done !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL %s done_wait: got no done pulse, required one within 3000 cycles", tag);
      end else begin
         chk({tag, " err"}, err, e_err);
         chk({tag, " err_code"}, err_code, e_code);
         chk({tag, " status_byte"}, status_byte, e_st);
         chk({tag, " bytes_left"}, exp_q.size(), 0);
         if (check_gap && tx_cyc.size() >= 2)
            chk({tag, " timeout_gap_ok"}, (tx_cyc[1] - tx_cyc[0] >= TO) && (tx_cyc[1] - tx_cyc[0] <= TO + 4), 1);
         @(negedge clk);
         chk({tag, " done_width"}, done, 1'b0);
         chk({tag, " busy_after"}, busy, 1'b0);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      push_expected(v);
      cfg_delay = v.delay; cfg_silent = v.silent; cfg_corrupt = v.corrupt; cfg_reply = v.reply;
      txn_idx = 0;
      tx_cyc.delete();
      issue(v.op, v.arg, v.len);
      wait_done_and_check($sformatf("vec%0d", idx), v.e_err, v.e_code, v.e_st, v.silent);
   endtask

   initial begin
      logic [7:0] val;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset err_code", err_code, 0);
      chk("reset status_byte", status_byte, 0);
      chk("reset tx_start", tx_start, 0);
      chk("reset tx_data", tx_data, 0);
      rst_n = 1'b1;

      for (int i = 0; i < int'(MAXE); i++) begin
         val = (i == 0) ? 8'd5 : (i == 1) ? 8'd17 : (i == 2) ? 8'd40 : 8'($urandom_range(0, 255));
         @(negedge clk);
         tbl_we = 1'b1; tbl_addr = 6'(i); tbl_data = val;
         shadow[i] = val;
      end
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = 6'd60; tbl_data = 8'hAA;
      @(negedge clk);
      tbl_we = 1'b0;

      //            op    arg    len   dly sil cor  reply ab  err code st
      vecs[0]  = mk(3'd0, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 0, 0, 8'd0);
      vecs[1]  = mk(3'd1, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 0, 0, 8'd0);
      vecs[2]  = mk(3'd3, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 0, 0, 8'd0);
      vecs[3]  = mk(3'd2, 8'h00, 6'd3,   2, 0, -1, 8'd0,  -1, 0, 0, 8'd0);
      vecs[4]  = mk(3'd5, 8'h00, 6'd0,   2, 0, -1, 8'd2,  -1, 0, 0, 8'd2);
      vecs[5]  = mk(3'd5, 8'h00, 6'd0,   2, 0, -1, 8'd99, -1, 0, 0, 8'd99);
      vecs[6]  = mk(3'd4, 8'h1A, 6'd0,   2, 0,  1, 8'd0,   2, 1, 2, 8'd99);
      vecs[7]  = mk(3'd0, 8'h00, 6'd0,   2, 1, -1, 8'd0,   1, 1, 1, 8'd99);
      vecs[8]  = mk(3'd2, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 1, 3, 8'd99);
      vecs[9]  = mk(3'd6, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 1, 3, 8'd99);
      vecs[10] = mk(3'd7, 8'h00, 6'd0,   2, 0, -1, 8'd0,  -1, 1, 3, 8'd99);
      vecs[11] = mk(3'd2, 8'h00, 6'd52,  2, 0, -1, 8'd0,  -1, 1, 3, 8'd99);
      vecs[12] = mk(3'd4, 8'hF5, 6'd0,   2, 0, -1, 8'd0,  -1, 0, 0, 8'd99);
      vecs[13] = mk(3'd0, 8'h00, 6'd0,  99, 0, -1, 8'd0,  -1, 0, 0, 8'd99);
      vecs[14] = mk(3'd0, 8'h00, 6'd0, 100, 0, -1, 8'd0,   1, 1, 1, 8'd99);
      vecs[15] = mk(3'd2, 8'h00, 6'd51,  2, 0, -1, 8'd0,  -1, 0, 0, 8'd99);
      vecs[16] = mk(3'd2, 8'h00, 6'd3,   2, 0,  4, 8'd0,   5, 1, 2, 8'd99);
      vecs[17] = mk(3'd5, 8'h00, 6'd0,   2, 0, -1, 8'd63, -1, 0, 0, 8'd63);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // A second cmd_start while busy must not disturb the running ARM.
      exp_q.push_back(8'd65);
      cfg_delay = 2; cfg_silent = 0; cfg_corrupt = -1; txn_idx = 0; tx_cyc.delete();
      @(negedge clk);
      cmd_op = 3'd0; tbl_len = '0; cmd_start = 1'b1;
      @(negedge clk);
      cmd_op = 3'd3;
      chk("busy_active", busy, 1);
      @(negedge clk);
      cmd_start = 1'b0;
      wait_done_and_check("ignore_start", 1'b0, 2'd0, 8'd63, 1'b0);

      // Reset during the third LOAD byte: no abort byte, then normal service.
      exp_q.push_back(8'd66);
      exp_q.push_back({3'b0, shadow[0][4:0]});
      exp_q.push_back({3'b0, shadow[1][4:0]});
      txn_idx = 0;
      issue(3'd2, 8'h00, 6'd3);
      for (int c = 0; c < 500 && txn_idx < 3; c++) @(negedge clk);
      chk("mid_reset reached_byte3", txn_idx >= 3, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset busy", busy, 0);
      chk("mid_reset done", done, 0);
      chk("mid_reset err_code", err_code, 0);
      chk("mid_reset status_byte", status_byte, 0);
      chk("mid_reset tx_start", tx_start, 0);
      chk("mid_reset tx_data", tx_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_reset bytes_left", exp_q.size(), 0);
      run_vec(100, mk(3'd0, 8'h00, 6'd0, 2, 0, -1, 8'd0, -1, 0, 0, 8'd0));
      run_vec(101, mk(3'd2, 8'h00, 6'd3, 2, 0, -1, 8'd0, -1, 0, 0, 8'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
